// File: rtl/hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline sequencing controller and the EX-stage
//   forwarding logic: FSM state encoding, the hard-wired zero register index,
//   the bundle of pipeline-register control enables and the load-use
//   detection helper.
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  // x0 is hard-wired to zero, so it never carries a real data dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT,
    HALT     = ST_HALT
  } hz_state_e;

  // Stall/flush enables for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Whole pipeline frozen, MEM/WB gets a bubble so nothing retires twice.
  localparam hz_ctrl_t CTRL_FREEZE  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  // Squash the two younger instructions behind a taken branch.
  localparam hz_ctrl_t CTRL_BRANCH  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  // Hold IF and ID, push one bubble into EX behind the load.
  localparam hz_ctrl_t CTRL_LOADUSE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // True when the ID instruction reads the register a load in EX will write.
  function automatic logic is_loaduse(
    input logic       ex_memread,
    input logic [4:0] ex_rd,
    input logic       uses_rs1,
    input logic [4:0] rs1,
    input logic       uses_rs2,
    input logic [4:0] rs2
  );
    logic hit_rs1;
    logic hit_rs2;
    hit_rs1 = uses_rs1 & (rs1 == ex_rd);
    hit_rs2 = uses_rs2 & (rs2 == ex_rd);
    return ex_memread & (ex_rd != REG_ZERO) & (hit_rs1 | hit_rs2);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_controller_if
//   Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives hazard inputs, receives enables/counters.
//   slave  : controller side.
//   Inputs : id_rs1/id_rs2/id_uses_rs1/id_uses_rs2, ex_rd, ex_memread,
//            ex_branch_taken, dmem_req, dmem_ready.
//   Outputs: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
//            exmem_stall, memwb_bubble, halted, stall_cycles, flush_count.
// ---------------------------------------------------------------------------
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_stall;
  logic             memwb_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_bubble, halted, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_bubble, halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   value : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  // Count register: clear on reset, increment unless already saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= {W{1'b0}};
    end else if (inc && (value != ALL_ONES)) begin
      value <= value + W'(1);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencing for the 5-stage core: resolves load-use hazards with
//   a single bubble, flushes behind taken branches and freezes the pipe while
//   data memory is busy, escalating to a sticky HALT if memory never answers.
//   Enables are combinational from state and current inputs.
//   clk, rst : clock and synchronous active-high reset
//   hz       : hazard_controller_if.slave (hazard inputs, enables, counters)
// ---------------------------------------------------------------------------
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hz
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e          state_r;
  hz_state_e          state_nxt_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [WAIT_W-1:0]  wait_cnt_nxt_s;
  logic               halted_r;
  logic               halt_set_s;

  logic               memwait_s;
  logic               loaduse_s;
  hz_ctrl_t           ctrl_s;
  logic               branch_flush_s;
  logic [CNT_W-1:0]   stall_cycles_s;
  logic [CNT_W-1:0]   flush_count_s;

  assign memwait_s = hz.dmem_req & ~hz.dmem_ready;
  assign loaduse_s = is_loaduse(hz.ex_memread, hz.ex_rd,
                                hz.id_uses_rs1, hz.id_rs1,
                                hz.id_uses_rs2, hz.id_rs2);

  // Enable generation: memory wait beats branch beats load-use.
  always_comb begin
    ctrl_s         = CTRL_NONE;
    branch_flush_s = 1'b0;
    if (rst) begin
      ctrl_s = CTRL_NONE;
    end else if (state_r == HALT) begin
      ctrl_s = CTRL_FREEZE;
    end else if (memwait_s) begin
      // Branch/load-use are simply re-seen once memory releases the pipe.
      ctrl_s = CTRL_FREEZE;
    end else if (hz.ex_branch_taken) begin
      // The ID instruction is squashed, so any load-use on it is moot.
      ctrl_s         = CTRL_BRANCH;
      branch_flush_s = 1'b1;
    end else if (loaduse_s) begin
      // One bubble suffices: next cycle the load sits in MEM and forwards.
      ctrl_s = CTRL_LOADUSE;
    end else begin
      ctrl_s = CTRL_NONE;
    end
  end

  // Next-state and wait-count logic for the memory wait / timeout FSM.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    halt_set_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (memwait_s) begin
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = WAIT_W'(1);
        end else begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (memwait_s) begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_nxt_s = HALT;
            halt_set_s  = 1'b1;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
          end
        end else begin
          // Either the access completed or the request went away.
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end
    endcase
  end

  // State, wait counter and sticky halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      halted_r   <= halted_r | halt_set_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl_s.pc_stall),
    .value (stall_cycles_s)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush_s),
    .value (flush_count_s)
  );

  assign hz.pc_stall     = ctrl_s.pc_stall;
  assign hz.ifid_stall   = ctrl_s.ifid_stall;
  assign hz.ifid_flush   = ctrl_s.ifid_flush;
  assign hz.idex_stall   = ctrl_s.idex_stall;
  assign hz.idex_flush   = ctrl_s.idex_flush;
  assign hz.exmem_stall  = ctrl_s.exmem_stall;
  assign hz.memwb_bubble = ctrl_s.memwb_bubble;
  assign hz.halted       = halted_r;
  assign hz.stall_cycles = stall_cycles_s;
  assign hz.flush_count  = flush_count_s;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage core; pairs with the EX-stage operand forwarding logic.
- Handles the hazards forwarding cannot resolve:
  - load-use stall, one bubble;
  - taken-branch flush;
  - multi-cycle data-memory wait freeze, with timeout-to-halt.
- Drives stall/flush enables of the PC and pipeline registers; keeps saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive dmem wait cycles before HALT (>=2).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  EX-stage destination register.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved taken branch/jump.
- dmem_req  in  1  MEM stage has an active data-memory access.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID register.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_stall  out  1  hold ID/EX register.
- idex_flush  out  1  load NOP into ID/EX.
- exmem_stall  out  1  hold EX/MEM register.
- memwb_bubble  out  1  load NOP into MEM/WB.
- halted  out  1  sticky memory-timeout halt.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1.
- flush_count  out  CNT_W  saturating count of branch flushes.

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Register wait_cnt holds the MEM_WAIT cycle count.
- Reset (rst=1 at edge): state=RUN, wait_cnt=0, counters=0, halted=0.
  - While rst is high, all stall/flush/bubble outputs = 0.
  - Reset in any state, including HALT or mid-wait, returns to RUN next cycle.
- Outputs are combinational from state + current inputs; zero latency.

Definitions:
- memwait = dmem_req & !dmem_ready.
- loaduse = ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).

RUN / MEM_WAIT output priority (highest first):
1. memwait: pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble = 1. No flushes, even if ex_branch_taken or loaduse are also true; they are re-evaluated after release.
2. ex_branch_taken: ifid_flush = 1, idex_flush = 1, no stalls. Overrides a simultaneous loaduse, because the ID instruction is squashed.
3. loaduse: pc_stall, ifid_stall, idex_flush = 1.
   - Exactly one bubble; the next cycle the load is in MEM and forwarding covers it.
   - No state is held for this.
4. Otherwise all outputs 0.

Transitions:
- RUN -> MEM_WAIT when memwait, wait_cnt <= 1.
- MEM_WAIT with dmem_ready=1:
  - Outputs follow the non-memwait rules this same cycle.
  - Next state RUN, wait_cnt <= 0.
- MEM_WAIT with memwait and wait_cnt == MEM_TIMEOUT-1 -> HALT, halted <= 1.
- MEM_WAIT with memwait otherwise: wait_cnt <= wait_cnt+1.
- MEM_WAIT with dmem_req dropped (no request): return to RUN.
- HALT: pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble = 1 and flushes = 0, regardless of inputs, until rst.

Counters:
- stall_cycles increments on each cycle with pc_stall=1, including HALT; it saturates at all-ones.
- flush_count increments on each cycle with ifid_flush=1 from a branch; it saturates.
- Neither counter increments during rst.

Register 0 never causes a load-use stall.

Decomposition:
- Shared package pipeline_ctrl_pkg:
  - state encoding localparams ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_HALT=2'd2;
  - REG_ZERO=5'd0.
  - The forwarding logic reuses REG_ZERO.
- One natural sub-module: sat_counter (parameter W; inc, rst, value), instantiated twice.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only; stall_cycles=1.
- Load to x0: ex_rd=0, id_rs1=0 -> no stall.
- Branch with simultaneous load-use: ex_branch_taken=1 and the load-use condition above -> ifid_flush=idex_flush=1, pc_stall=0; flush_count=1.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high ->
  - all four stalls + memwb_bubble high for 3 cycles;
  - state back to RUN;
  - stall_cycles=3.
- Timeout: MEM_TIMEOUT=16, dmem_ready held 0 ->
  - halted=1 after 16 wait cycles;
  - outputs stay frozen with inputs toggled;
  - rst pulse -> RUN, halted=0, counters=0.
- Reset mid-wait: assert rst on wait cycle 2 -> outputs 0 during rst, wait_cnt=0, RUN afterward.
